// File: rtl/game_timer_pkg.sv
// Shared definitions for the ping-pong game timebase.
// Covers the phase encoding, the ball-step period per speed level and the counter sizing helper.
package game_timer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_COUNTDOWN = 3'd1,
        PH_RUN       = 3'd2,
        PH_PAUSED    = 3'd3,
        PH_SERVE     = 3'd4
    } phase_t;

    localparam int PHASE_W = 3;

    function automatic int stepPeriod(input int level, input int init, input int dec);
        return init - level * dec;
    endfunction

    // Bits needed for a counter holding 0..n-1; never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/game_timer_controller_tick_prescaler.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// It is the single free-running counter of the game timebase; clear overrides enable.
module tick_prescaler
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = cntWidth(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Tick is high during the cycle whose closing edge wraps the count back to zero.
    assign tick = enable && (r_count == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == CNT_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/game_timer_controller.sv
// Round-phase sequencer for the ping-pong game: schedules the shared prescaler across
// countdown, run, pause and serve, and emits ball_step pulses that speed up with paddle hits.
module game_timer_controller
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV        = 50000,
    parameter int TICKS_PER_SEC   = 1000,
    parameter int COUNTDOWN_SECS  = 3,
    parameter int SERVE_TICKS     = 500,
    parameter int STEP_TICKS_INIT = 20,
    parameter int STEP_TICKS_DEC  = 4,
    parameter int SPEED_LEVELS    = 4,
    parameter int HITS_PER_LEVEL  = 4
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  pause_toggle,
    input  logic                                  hit,
    input  logic                                  point_scored,
    input  logic                                  game_over,
    output logic                                  ball_step,
    output logic [cntWidth(COUNTDOWN_SECS+1)-1:0] countdown,
    output logic [cntWidth(SPEED_LEVELS)-1:0]     speed_level,
    output logic [PHASE_W-1:0]                    phase,
    output logic                                  running
);

    localparam int CD_W   = cntWidth(COUNTDOWN_SECS + 1);
    localparam int LV_W   = cntWidth(SPEED_LEVELS);
    localparam int SEC_W  = cntWidth(TICKS_PER_SEC);
    localparam int STEP_W = cntWidth(STEP_TICKS_INIT);
    localparam int SRV_W  = cntWidth(SERVE_TICKS);
    localparam int HIT_W  = cntWidth(HITS_PER_LEVEL);

    localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(COUNTDOWN_SECS);
    localparam logic [CD_W-1:0]  CD_ONE   = CD_W'(1);
    localparam logic [LV_W-1:0]  LV_MAX   = LV_W'(SPEED_LEVELS - 1);
    localparam logic [LV_W-1:0]  LV_ONE   = LV_W'(1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_TICKS - 1);
    localparam logic [SRV_W-1:0] SRV_ONE  = SRV_W'(1);
    localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HITS_PER_LEVEL - 1);
    localparam logic [HIT_W-1:0] HIT_ONE  = HIT_W'(1);

    if (STEP_TICKS_INIT - (SPEED_LEVELS - 1) * STEP_TICKS_DEC < 1) begin : g_badStepConfig
        $error("game_timer_controller: fastest step period must be at least one tick");
    end

    phase_t              r_phase;
    phase_t              r_returnPhase;
    logic [SEC_W-1:0]    r_secCnt;
    logic [STEP_W-1:0]   r_stepCnt;
    logic [SRV_W-1:0]    r_serveCnt;
    logic [HIT_W-1:0]    r_hitCnt;
    logic [CD_W-1:0]     r_countdown;
    logic [LV_W-1:0]     r_speedLevel;
    logic                r_ballStep;
    logic                r_running;

    phase_t              w_nextPhase;
    phase_t              w_nextReturn;
    logic                w_tick;
    logic                w_prescalerEn;
    logic                w_prescalerClr;
    logic                w_phaseChange;
    logic                w_freshEntry;
    logic                w_gameOver;
    logic                w_secDue;
    logic                w_stepDue;
    logic                w_serveDue;
    logic [STEP_W-1:0]   w_stepLast;
    logic [SEC_W-1:0]    w_secCntNext;
    logic [STEP_W-1:0]   w_stepCntNext;
    logic [SRV_W-1:0]    w_serveCntNext;
    logic [HIT_W-1:0]    w_hitCntNext;
    logic [CD_W-1:0]     w_countdownNext;
    logic [LV_W-1:0]     w_speedLevelNext;
    logic                w_ballStepNext;
    logic                w_runningNext;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (w_prescalerEn),
        .clear  (w_prescalerClr),
        .tick   (w_tick)
    );

    // Fresh entry restarts the timebase; moves into or out of PAUSED keep it where it was.
    assign w_gameOver     = game_over && (r_phase != PH_IDLE);
    assign w_phaseChange  = (w_nextPhase != r_phase);
    assign w_freshEntry   = w_phaseChange && (r_phase != PH_PAUSED) && (w_nextPhase != PH_PAUSED);
    assign w_prescalerEn  = (r_phase == PH_COUNTDOWN) || (r_phase == PH_RUN) || (r_phase == PH_SERVE);
    assign w_prescalerClr = (w_nextPhase == PH_IDLE) || w_freshEntry;

    assign w_stepLast = STEP_W'(stepPeriod(int'(r_speedLevel), STEP_TICKS_INIT, STEP_TICKS_DEC) - 1);
    assign w_secDue   = (r_phase == PH_COUNTDOWN) && w_tick && (r_secCnt == SEC_LAST);
    // A level change can leave step_cnt above the shorter period; >= lets it fire rather than wrap.
    assign w_stepDue  = (r_phase == PH_RUN) && w_tick && (r_stepCnt >= w_stepLast);
    assign w_serveDue = (r_phase == PH_SERVE) && w_tick && (r_serveCnt == SRV_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase       <= PH_IDLE;
            r_returnPhase <= PH_IDLE;
        end else begin
            r_phase       <= w_nextPhase;
            r_returnPhase <= w_nextReturn;
        end
    end

    always_comb begin
        w_nextPhase  = r_phase;
        w_nextReturn = r_returnPhase;
        if (w_gameOver) begin
            w_nextPhase  = PH_IDLE;
            w_nextReturn = PH_IDLE;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        w_nextPhase = PH_COUNTDOWN;
                    end
                end
                PH_COUNTDOWN: begin
                    if (pause_toggle) begin
                        w_nextPhase  = PH_PAUSED;
                        w_nextReturn = PH_COUNTDOWN;
                    end else if (w_secDue && (r_countdown == CD_ONE)) begin
                        w_nextPhase = PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (point_scored) begin
                        w_nextPhase = PH_SERVE;
                    end else if (pause_toggle) begin
                        w_nextPhase  = PH_PAUSED;
                        w_nextReturn = PH_RUN;
                    end
                end
                PH_SERVE: begin
                    if (pause_toggle) begin
                        w_nextPhase  = PH_PAUSED;
                        w_nextReturn = PH_SERVE;
                    end else if (w_serveDue) begin
                        w_nextPhase = PH_RUN;
                    end
                end
                PH_PAUSED: begin
                    if (pause_toggle) begin
                        w_nextPhase = r_returnPhase;
                    end
                end
                default: begin
                    w_nextPhase  = PH_IDLE;
                    w_nextReturn = PH_IDLE;
                end
            endcase
        end
    end

    // Next values of the phase counters and registered outputs; any phase change mutes ball_step.
    always_comb begin
        w_secCntNext     = r_secCnt;
        w_stepCntNext    = r_stepCnt;
        w_serveCntNext   = r_serveCnt;
        w_hitCntNext     = r_hitCnt;
        w_countdownNext  = r_countdown;
        w_speedLevelNext = r_speedLevel;
        w_ballStepNext   = 1'b0;
        w_runningNext    = (w_nextPhase == PH_RUN);
        if (w_gameOver) begin
            w_secCntNext     = '0;
            w_stepCntNext    = '0;
            w_serveCntNext   = '0;
            w_hitCntNext     = '0;
            w_countdownNext  = '0;
            w_speedLevelNext = '0;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (start) begin
                        w_countdownNext  = CD_INIT;
                        w_speedLevelNext = '0;
                        w_hitCntNext     = '0;
                    end
                end
                PH_COUNTDOWN: begin
                    if (!pause_toggle && w_tick) begin
                        if (w_secDue) begin
                            w_secCntNext    = '0;
                            w_countdownNext = r_countdown - CD_ONE;
                        end else begin
                            w_secCntNext = r_secCnt + SEC_ONE;
                        end
                    end
                end
                PH_RUN: begin
                    if (point_scored) begin
                        w_speedLevelNext = '0;
                        w_hitCntNext     = '0;
                    end else if (!pause_toggle) begin
                        if (hit && (r_speedLevel != LV_MAX)) begin
                            if (r_hitCnt == HIT_LAST) begin
                                w_speedLevelNext = r_speedLevel + LV_ONE;
                                w_hitCntNext     = '0;
                            end else begin
                                w_hitCntNext = r_hitCnt + HIT_ONE;
                            end
                        end
                        if (w_tick) begin
                            if (w_stepDue) begin
                                w_stepCntNext  = '0;
                                w_ballStepNext = 1'b1;
                            end else begin
                                w_stepCntNext = r_stepCnt + STEP_ONE;
                            end
                        end
                    end
                end
                PH_SERVE: begin
                    if (!pause_toggle && w_tick) begin
                        if (w_serveDue) begin
                            w_serveCntNext = '0;
                        end else begin
                            w_serveCntNext = r_serveCnt + SRV_ONE;
                        end
                    end
                end
                default: begin
                    w_secCntNext = r_secCnt;
                end
            endcase
            if (w_freshEntry) begin
                w_secCntNext   = '0;
                w_stepCntNext  = '0;
                w_serveCntNext = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_secCnt     <= '0;
            r_stepCnt    <= '0;
            r_serveCnt   <= '0;
            r_hitCnt     <= '0;
            r_countdown  <= '0;
            r_speedLevel <= '0;
            r_ballStep   <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_secCnt     <= w_secCntNext;
            r_stepCnt    <= w_stepCntNext;
            r_serveCnt   <= w_serveCntNext;
            r_hitCnt     <= w_hitCntNext;
            r_countdown  <= w_countdownNext;
            r_speedLevel <= w_speedLevelNext;
            r_ballStep   <= w_ballStepNext;
            r_running    <= w_runningNext;
        end
    end

    assign ball_step   = r_ballStep;
    assign countdown   = r_countdown;
    assign speed_level = r_speedLevel;
    assign phase       = r_phase;
    assign running     = r_running;

endmodule

// File: tb/tb_game_timer_controller.sv
// Directed bench for game_timer_controller using small timing parameters and
// hand-computed cycle positions for countdown, step spacing, pause, serve and reset.
module tb_game_timer_controller;

    localparam int PH_IDLE      = 0;
    localparam int PH_COUNTDOWN = 1;
    localparam int PH_RUN       = 2;
    localparam int PH_PAUSED    = 3;
    localparam int PH_SERVE     = 4;

    logic       clock;
    logic       reset;
    logic       start;
    logic       pauseToggle;
    logic       hit;
    logic       pointScored;
    logic       gameOver;
    logic       ballStep;
    logic [1:0] countdown;
    logic [1:0] speedLevel;
    logic [2:0] phase;
    logic       running;

    int nChecks  = 0;
    int nBad     = 0;
    int stepSeen = 0;

    game_timer_controller #(
        .TICK_DIV        (4),
        .TICKS_PER_SEC   (5),
        .COUNTDOWN_SECS  (3),
        .SERVE_TICKS     (6),
        .STEP_TICKS_INIT (8),
        .STEP_TICKS_DEC  (2),
        .SPEED_LEVELS    (4),
        .HITS_PER_LEVEL  (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pause_toggle (pauseToggle),
        .hit          (hit),
        .point_scored (pointScored),
        .game_over    (gameOver),
        .ball_step    (ballStep),
        .countdown    (countdown),
        .speed_level  (speedLevel),
        .phase        (phase),
        .running      (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n clocks, sampling 1 ns after each rising edge and tallying ball_step pulses.
    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (ballStep === 1'b1) stepSeen++;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic h,
                                 input logic pt, input logic g);
        start       = s;
        pauseToggle = p;
        hit         = h;
        pointScored = pt;
        gameOver    = g;
        waitCycles(1);
        start       = 1'b0;
        pauseToggle = 1'b0;
        hit         = 1'b0;
        pointScored = 1'b0;
        gameOver    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nBad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pauseToggle = 1'b0;
        hit         = 1'b0;
        pointScored = 1'b0;
        gameOver    = 1'b0;

        waitCycles(2);
        checkOutput("rst_phase", 32'(phase), PH_IDLE);
        checkOutput("rst_step", 32'(ballStep), 0);
        checkOutput("rst_countdown", 32'(countdown), 0);
        checkOutput("rst_speed", 32'(speedLevel), 0);
        checkOutput("rst_running", 32'(running), 0);
        reset = 1'b0;

        $display("[TB] idle ignores everything but start");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("idle_ignore_phase", 32'(phase), PH_IDLE);
        checkOutput("idle_ignore_countdown", 32'(countdown), 0);

        $display("[TB] countdown");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cd_entry_phase", 32'(phase), PH_COUNTDOWN);
        checkOutput("cd_entry_value", 32'(countdown), 3);
        waitCycles(19);
        checkOutput("cd_19_value", 32'(countdown), 3);
        waitCycles(1);
        checkOutput("cd_20_value", 32'(countdown), 2);
        waitCycles(20);
        checkOutput("cd_40_value", 32'(countdown), 1);
        waitCycles(19);
        checkOutput("cd_59_phase", 32'(phase), PH_COUNTDOWN);
        checkOutput("cd_59_running", 32'(running), 0);
        waitCycles(1);
        checkOutput("cd_60_value", 32'(countdown), 0);
        checkOutput("cd_60_phase", 32'(phase), PH_RUN);
        checkOutput("cd_60_running", 32'(running), 1);

        $display("[TB] level 0 stepping");
        stepSeen = 0;
        waitCycles(31);
        checkOutput("l0_early_none", 32'(stepSeen), 0);
        waitCycles(1);
        checkOutput("l0_first_step", 32'(ballStep), 1);
        waitCycles(1);
        checkOutput("l0_pulse_width", 32'(ballStep), 0);
        stepSeen = 0;
        waitCycles(31);
        checkOutput("l0_second_step", 32'(ballStep), 1);
        checkOutput("l0_spacing_count", 32'(stepSeen), 1);

        $display("[TB] speed levels");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("l1_level", 32'(speedLevel), 1);
        stepSeen = 0;
        waitCycles(22);
        checkOutput("l1_first_step", 32'(ballStep), 1);
        checkOutput("l1_first_count", 32'(stepSeen), 1);
        stepSeen = 0;
        waitCycles(24);
        checkOutput("l1_second_step", 32'(ballStep), 1);
        checkOutput("l1_spacing_count", 32'(stepSeen), 1);
        stepSeen = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("l3_level", 32'(speedLevel), 3);
        waitCycles(4);
        checkOutput("l3_first_step", 32'(ballStep), 1);
        checkOutput("l3_first_count", 32'(stepSeen), 1);
        stepSeen = 0;
        waitCycles(8);
        checkOutput("l3_second_step", 32'(ballStep), 1);
        checkOutput("l3_spacing_count", 32'(stepSeen), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("l3_saturate", 32'(speedLevel), 3);
        waitCycles(6);
        checkOutput("l3_after_sat_step", 32'(ballStep), 1);

        $display("[TB] point with hit and pause on a step-due cycle");
        waitCycles(7);
        stepSeen = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("serve_phase", 32'(phase), PH_SERVE);
        checkOutput("serve_speed", 32'(speedLevel), 0);
        checkOutput("serve_no_step", 32'(ballStep), 0);
        checkOutput("serve_running", 32'(running), 0);
        waitCycles(23);
        checkOutput("serve_23_phase", 32'(phase), PH_SERVE);
        waitCycles(1);
        checkOutput("serve_24_phase", 32'(phase), PH_RUN);
        checkOutput("serve_24_running", 32'(running), 1);
        checkOutput("serve_steps", 32'(stepSeen), 0);

        $display("[TB] pause and resume");
        waitCycles(32);
        checkOutput("rerun_step", 32'(ballStep), 1);
        waitCycles(9);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pause_phase", 32'(phase), PH_PAUSED);
        checkOutput("pause_running", 32'(running), 0);
        stepSeen = 0;
        waitCycles(100);
        checkOutput("pause_hold_phase", 32'(phase), PH_PAUSED);
        checkOutput("pause_no_steps", 32'(stepSeen), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_phase", 32'(phase), PH_RUN);
        checkOutput("resume_running", 32'(running), 1);
        waitCycles(21);
        checkOutput("resume_early_none", 32'(stepSeen), 0);
        waitCycles(1);
        checkOutput("resume_step_22", 32'(ballStep), 1);

        $display("[TB] async reset mid-run");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("prereset_speed", 32'(speedLevel), 1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_phase", 32'(phase), PH_IDLE);
        checkOutput("async_speed", 32'(speedLevel), 0);
        checkOutput("async_running", 32'(running), 0);
        checkOutput("async_step", 32'(ballStep), 0);
        checkOutput("async_countdown", 32'(countdown), 0);
        #2;
        reset = 1'b0;
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_phase", 32'(phase), PH_COUNTDOWN);
        checkOutput("restart_countdown", 32'(countdown), 3);

        $display("[TB] game over from countdown");
        waitCycles(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("gameover_phase", 32'(phase), PH_IDLE);
        checkOutput("gameover_countdown", 32'(countdown), 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
